// File: rtl/lcd_panel_responder.sv
// Panel-side responder for an 8-bit HD44780-style character-LCD bus.
// Latches bus cycles on the falling edge of enable, runs a subset of the instruction set and holds DDRAM.
module lcd_panel_responder #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              enable,
    input  logic              rw,
    input  logic              rs,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              display_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              overrun,
    input  logic [ADDR_W-1:0] view_addr,
    output logic [7:0]        view_char
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned EW    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [7:0]  BLANK = 8'h20;

    typedef enum logic [1:0] {IDLE, CLEAR, EXEC} state_t;

    logic [7:0]        mem [DEPTH];
    state_t            state;
    logic              en_q;
    logic [7:0]        d_q;
    logic              rs_q;
    logic              rw_q;
    logic              incr;
    logic [ADDR_W-1:0] clr_cnt;
    logic [EW-1:0]     exec_cnt;

    logic              fire;
    logic [ADDR_W-1:0] next_addr;
    logic              cmd_addr, cmd_disp, cmd_entry, cmd_home, cmd_clear, cmd_exec;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    assign fire      = en_q & ~enable;
    assign next_addr = incr ? cursor_addr + ADDR_W'(1) : cursor_addr - ADDR_W'(1);

    // Instruction class by highest set bit; 001xxxxx/01xxxxxx/0001xxxx/0x00 fall through as no-ops.
    assign cmd_addr  = d_q[7];
    assign cmd_disp  = (d_q[7:3] == 5'b00001);
    assign cmd_entry = (d_q[7:2] == 6'b000001);
    assign cmd_home  = (d_q[7:1] == 7'b0000001);
    assign cmd_clear = (d_q == 8'h01);
    assign cmd_exec  = cmd_addr | cmd_disp | cmd_entry | cmd_home;

    // DDRAM write port: init/clear fill has priority, otherwise idle data writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cursor_addr;
        mem_wdata = d_q;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = BLANK;
        end else if (state == IDLE && fire && rs_q && !rw_q) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        view_char <= mem[view_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            clr_cnt     <= '0;
            exec_cnt    <= '0;
            en_q        <= 1'b0;
            d_q         <= 8'h00;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            cursor_addr <= '0;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            incr        <= 1'b1;
            overrun     <= 1'b0;
            data_oe     <= 1'b0;
            data_out    <= 8'h00;
        end else begin
            en_q <= enable;
            if (enable) begin
                d_q  <= data_in;
                rs_q <= rs;
                rw_q <= rw;
            end

            data_oe <= enable & rw;
            if (enable && rw) begin
                if (rs) data_out <= busy ? 8'h00 : mem[cursor_addr];
                else    data_out <= {busy, 7'(cursor_addr)};
            end else begin
                data_out <= 8'h00;
            end

            if (fire && busy && !(rw_q && !rs_q)) overrun <= 1'b1;

            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        cursor_addr <= '0;
                        incr        <= 1'b1;
                    end
                end
                EXEC: begin
                    exec_cnt <= exec_cnt + EW'(1);
                    if (exec_cnt == EW'(EXEC_CYCLES - 1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        exec_cnt <= '0;
                    end
                end
                default: begin
                    if (fire && rs_q) begin
                        cursor_addr <= next_addr;
                    end else if (fire && !rw_q) begin
                        if (cmd_addr)  cursor_addr <= d_q[ADDR_W-1:0];
                        if (cmd_disp)  {display_on, cursor_on, blink_on} <= d_q[2:0];
                        if (cmd_entry) incr <= d_q[1];
                        if (cmd_home)  cursor_addr <= '0;
                        if (cmd_clear) begin
                            state   <= CLEAR;
                            busy    <= 1'b1;
                            clr_cnt <= '0;
                        end
                        if (cmd_exec && EXEC_CYCLES != 0) begin
                            state    <= EXEC;
                            busy     <= 1'b1;
                            exec_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed self-checking bench for lcd_panel_responder (ADDR_W=5, EXEC_CYCLES=2).
module tb_lcd_panel_responder;

    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        data_in;
    logic              enable;
    logic              rw;
    logic              rs;
    logic [7:0]        data_out;
    logic              data_oe;
    logic              busy;
    logic [ADDR_W-1:0] cursor_addr;
    logic              display_on;
    logic              cursor_on;
    logic              blink_on;
    logic              overrun;
    logic [ADDR_W-1:0] view_addr;
    logic [7:0]        view_char;

    int n_cmp = 0;
    int n_err = 0;

    lcd_panel_responder #(.ADDR_W(ADDR_W), .EXEC_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .enable(enable), .rw(rw), .rs(rs),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .cursor_addr(cursor_addr),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .overrun(overrun), .view_addr(view_addr), .view_char(view_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic r_s, input logic [7:0] d, input int len);
        @(posedge clk); #1;
        enable = 1'b1; rs = r_s; rw = 1'b0; data_in = d;
        repeat (len) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic r_s, input int len,
                            output logic [7:0] d, output logic oe_hi, output logic oe_lo);
        @(posedge clk); #1;
        enable = 1'b1; rs = r_s; rw = 1'b1;
        repeat (len) @(posedge clk);
        #1 d = data_out; oe_hi = data_oe; enable = 1'b0;
        @(posedge clk); #1;
        oe_lo = data_oe; rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic view_check(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        view_addr = a;
        @(posedge clk); #1;
        check(tag, view_char, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cursor"}, cursor_addr, 0);
        check({tag, "_dcb"}, {display_on, cursor_on, blink_on}, 3'b000);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_oe"}, data_oe, 0);
        check({tag, "_dout"}, data_out, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        logic       oe_hi, oe_lo;
        string      hello = "Hello";

        rst_n = 1'b0; enable = 1'b0; rw = 1'b0; rs = 1'b0; data_in = 8'h00; view_addr = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");

        // Init clear: busy for exactly 32 cycles after release.
        rst_n = 1'b1;
        repeat (31) @(posedge clk);
        #1 check("init_busy_31", busy, 1);
        @(posedge clk); #1;
        check("init_busy_32", busy, 0);
        check("init_cursor", cursor_addr, 0);
        view_check("init_v0", 5'd0, 8'h20);
        view_check("init_v17", 5'd17, 8'h20);
        view_check("init_v31", 5'd31, 8'h20);

        // Display control then "Hello".
        bus_write(1'b0, 8'h0F, 3);
        check("dctl_busy", busy, 1);
        wait_idle();
        check("dctl_bits", {display_on, cursor_on, blink_on}, 3'b111);
        for (int i = 0; i < 5; i++) bus_write(1'b1, hello[i], 3);
        check("hello_cursor", cursor_addr, 5);
        for (int i = 0; i < 5; i++) view_check("hello_char", ADDR_W'(i), hello[i]);

        // Set address 31, wrap up past the end, then decrement and wrap down.
        bus_write(1'b0, 8'h9F, 1);
        wait_idle();
        check("setaddr_cursor", cursor_addr, 31);
        bus_write(1'b1, 8'h41, 1);
        bus_write(1'b1, 8'h42, 1);
        check("wrap_up_cursor", cursor_addr, 1);
        view_check("wrap_v31", 5'd31, 8'h41);
        view_check("wrap_v0", 5'd0, 8'h42);
        bus_write(1'b0, 8'h04, 1);
        wait_idle();
        bus_write(1'b1, 8'h43, 1);
        check("dec_cursor", cursor_addr, 0);
        bus_write(1'b1, 8'h44, 1);
        check("wrap_down_cursor", cursor_addr, 31);
        view_check("dec_v1", 5'd1, 8'h43);
        view_check("dec_v0", 5'd0, 8'h44);

        // Clear, a dropped write during clear, and a busy-flag read during clear.
        check("overrun_pre", overrun, 0);
        bus_write(1'b0, 8'h01, 1);
        bus_write(1'b1, 8'h58, 1);
        check("overrun_set", overrun, 1);
        bus_read(1'b0, 2, d, oe_hi, oe_lo);
        check("bf_clear_data", d, 8'h9F);
        check("bf_clear_oe_hi", oe_hi, 1);
        check("bf_clear_oe_lo", oe_lo, 0);
        wait_idle();
        check("clear_cursor", cursor_addr, 0);
        view_check("clear_v0", 5'd0, 8'h20);
        view_check("clear_v1", 5'd1, 8'h20);
        view_check("clear_v31", 5'd31, 8'h20);
        bus_read(1'b0, 1, d, oe_hi, oe_lo);
        check("bf_idle_data", d, 8'h00);
        check("overrun_sticky", overrun, 1);

        // Data read advances the cursor without modifying DDRAM.
        bus_write(1'b0, 8'h82, 1);
        wait_idle();
        bus_write(1'b1, 8'h51, 1);
        bus_write(1'b0, 8'h82, 1);
        wait_idle();
        check("rd_cursor_pre", cursor_addr, 2);
        bus_read(1'b1, 2, d, oe_hi, oe_lo);
        check("rd_data", d, 8'h51);
        check("rd_oe_hi", oe_hi, 1);
        check("rd_oe_lo", oe_lo, 0);
        check("rd_cursor_post", cursor_addr, 3);
        view_check("rd_v2", 5'd2, 8'h51);

        // Asynchronous reset ten cycles into a clear, then a full rerun.
        bus_write(1'b0, 8'h01, 1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midclr");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (31) @(posedge clk);
        #1 check("rerun_busy_31", busy, 1);
        @(posedge clk); #1;
        check("rerun_busy_32", busy, 0);
        view_check("rerun_v2", 5'd2, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
